// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC generator: D-stage predicted-taken redirects, E-stage mispredict
// recovery (held pending behind stallF), F->D flush and saturating perf counters.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallF,
  input  logic             stallD,
  input  logic             stallE,
  input  logic             flushE,
  input  logic             branchD,
  input  logic             pred_takeD,
  input  logic [31:0]      pcD,
  input  logic [31:0]      branch_targetD,
  input  logic             actual_takeE,
  input  logic             preErrorE,
  output logic [31:0]      pcF,
  output logic             flush_D,
  output logic             redirect_busy,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic {RUN, PEND} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t      state;
  logic [31:0] pendPc;
  logic        branchE;
  logic [31:0] targetE;
  logic [31:0] fallE;

  logic        mispredE;
  logic [31:0] recoveryPc;
  logic [31:0] nextPc;

  always_comb begin
    mispredE   = branchE & preErrorE;
    recoveryPc = actual_takeE ? targetE : fallE;
    if (mispredE)
      nextPc = recoveryPc;
    else if (branchD & pred_takeD & ~stallD)
      nextPc = branch_targetD;
    else
      nextPc = pcF + 32'd4;
  end

  // Only the F instruction is wrong-path; the D instruction is the delay slot.
  assign flush_D       = ~rst & (mispredE | (state == PEND));
  assign redirect_busy = ~rst & (state == PEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pcF         <= RESET_PC;
      pendPc      <= 32'd0;
      branchE     <= 1'b0;
      targetE     <= 32'd0;
      fallE       <= 32'd0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!stallF) begin
            pcF <= nextPc;
          end else if (mispredE) begin
            pendPc <= recoveryPc;
            state  <= PEND;
          end
        end
        PEND: begin
          // A fresh mispredict supersedes the saved redirect.
          if (!stallF) begin
            pcF   <= mispredE ? recoveryPc : pendPc;
            state <= RUN;
          end else if (mispredE) begin
            pendPc <= recoveryPc;
          end
        end
        default: state <= RUN;
      endcase

      if (flushE) begin
        branchE <= 1'b0;
      end else if (!stallE) begin
        branchE <= branchD;
        targetE <= branch_targetD;
        fallE   <= pcD + 32'd8;
      end

      if (branchE && !stallE && branch_cnt != CNT_MAX)
        branch_cnt <= branch_cnt + CNT_ONE;
      if (mispredE && !stallE && mispred_cnt != CNT_MAX)
        mispred_cnt <= mispred_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed vector table, corner sequences and a
// randomized run against a behavioural reference model.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst, stallF, stallD, stallE, flushE, branchD, pred_takeD;
  logic [31:0] pcD, branch_targetD;
  logic        actual_takeE, preErrorE;
  logic [31:0] pcF, pcF4;
  logic        flush_D, redirect_busy, flush_D4, redirect_busy4;
  logic [15:0] branch_cnt, mispred_cnt;
  logic [3:0]  branch_cnt4, mispred_cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_pc_ctrl #(.RESET_PC(32'hBFC0_0000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushE(flushE), .branchD(branchD), .pred_takeD(pred_takeD), .pcD(pcD),
    .branch_targetD(branch_targetD), .actual_takeE(actual_takeE), .preErrorE(preErrorE),
    .pcF(pcF), .flush_D(flush_D), .redirect_busy(redirect_busy),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt));

  fetch_pc_ctrl #(.RESET_PC(32'hBFC0_0000), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushE(flushE), .branchD(branchD), .pred_takeD(pred_takeD), .pcD(pcD),
    .branch_targetD(branch_targetD), .actual_takeE(actual_takeE), .preErrorE(preErrorE),
    .pcF(pcF4), .flush_D(flush_D4), .redirect_busy(redirect_busy4),
    .branch_cnt(branch_cnt4), .mispred_cnt(mispred_cnt4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    stallF = 0; stallD = 0; stallE = 0; flushE = 0; branchD = 0; pred_takeD = 0;
    pcD = 32'd0; branch_targetD = 32'd0; actual_takeE = 0; preErrorE = 0;
  endtask

  // Inputs change #1 after a rising edge; outputs are sampled #1 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1; idle();
    step();
    rst = 0;
  endtask

  typedef struct {
    logic        bD, pT;
    logic [31:0] pcd, tgt;
    logic        act, perr;
    logic        expFlush;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs[8];

  // Reference model state
  logic [31:0] mPc, mPendPc, mTgt, mFall;
  bit          mPend, mBr;
  int          mBc, mMc, mBc4, mMc4;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic modelReset();
    mPc = 32'hBFC0_0000; mPend = 0; mPendPc = 0; mBr = 0; mTgt = 0; mFall = 0;
    mBc = 0; mMc = 0; mBc4 = 0; mMc4 = 0;
  endtask

  task automatic modelEdge();
    bit          mis;
    logic [31:0] rec;
    mis = mBr && preErrorE;
    rec = actual_takeE ? mTgt : mFall;
    if (mPend) begin
      if (mis) mPendPc = rec;
      if (!stallF) begin mPc = mPendPc; mPend = 0; end
    end else if (!stallF) begin
      if (mis)                                mPc = rec;
      else if (branchD && pred_takeD && !stallD) mPc = branch_targetD;
      else                                    mPc = mPc + 32'd4;
    end else if (mis) begin
      mPend = 1; mPendPc = rec;
    end
    if (!stallE && mBr) begin mBc = sat(mBc + 1, 65535); mBc4 = sat(mBc4 + 1, 15); end
    if (!stallE && mis) begin mMc = sat(mMc + 1, 65535); mMc4 = sat(mMc4 + 1, 15); end
    if (flushE) mBr = 0;
    else if (!stallE) begin mBr = branchD; mTgt = branch_targetD; mFall = pcD + 32'd8; end
  endtask

  initial begin
    vecs[0] = '{0, 0, 32'h0,    32'h0,   0, 0, 0, 32'hBFC0_0004};
    vecs[1] = '{0, 0, 32'h0,    32'h0,   0, 0, 0, 32'hBFC0_0008};
    vecs[2] = '{0, 0, 32'h0,    32'h0,   0, 0, 0, 32'hBFC0_000C};
    vecs[3] = '{1, 1, 32'h100,  32'h200, 0, 0, 0, 32'h200};
    vecs[4] = '{0, 0, 32'h0,    32'h0,   0, 1, 1, 32'h108};
    vecs[5] = '{1, 0, 32'h1000, 32'h300, 0, 0, 0, 32'h10C};
    vecs[6] = '{1, 1, 32'h40,   32'h500, 1, 1, 1, 32'h300};
    vecs[7] = '{0, 0, 32'h0,    32'h0,   0, 0, 0, 32'h304};

    doReset();
    check("reset_pcF", pcF, 32'hBFC0_0000);
    check("reset_flush", {31'd0, flush_D}, 32'd0);
    check("reset_busy", {31'd0, redirect_busy}, 32'd0);
    check("reset_bcnt", {16'd0, branch_cnt}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      branchD = vecs[i].bD; pred_takeD = vecs[i].pT; pcD = vecs[i].pcd;
      branch_targetD = vecs[i].tgt; actual_takeE = vecs[i].act; preErrorE = vecs[i].perr;
      #1;
      check($sformatf("vec%0d_flush", i), {31'd0, flush_D}, {31'd0, vecs[i].expFlush});
      step();
      check($sformatf("vec%0d_pcF", i), pcF, vecs[i].expPc);
    end
    check("vec_bcnt", {16'd0, branch_cnt}, 32'd3);
    check("vec_mcnt", {16'd0, mispred_cnt}, 32'd2);

    // Mispredict under a 3-cycle stallF, then release.
    doReset();
    branchD = 1; pcD = 32'h2000; branch_targetD = 32'h4000;
    step();
    idle();
    preErrorE = 1; actual_takeE = 1; stallF = 1; stallD = 1;
    #1 check("stall_flush0", {31'd0, flush_D}, 32'd1);
    step();
    preErrorE = 0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("stall_busy%0d", i), {31'd0, redirect_busy}, 32'd1);
      check($sformatf("stall_flush%0d", i + 1), {31'd0, flush_D}, 32'd1);
      check($sformatf("stall_pcF%0d", i), pcF, 32'hBFC0_0004);
      step();
    end
    stallF = 0; stallD = 0;
    check("stall_busy_last", {31'd0, redirect_busy}, 32'd1);
    step();
    check("stall_recover_pcF", pcF, 32'h4000);
    check("stall_busy_clear", {31'd0, redirect_busy}, 32'd0);
    check("stall_flush_clear", {31'd0, flush_D}, 32'd0);

    // Reset while a redirect is pending discards it.
    branchD = 1; pcD = 32'h2000; branch_targetD = 32'h4000;
    step();
    idle();
    preErrorE = 1; stallF = 1; stallD = 1;
    step();
    check("pend_busy", {31'd0, redirect_busy}, 32'd1);
    rst = 1; preErrorE = 0;
    #1;
    check("rst_pend_flush", {31'd0, flush_D}, 32'd0);
    check("rst_pend_busy", {31'd0, redirect_busy}, 32'd0);
    step();
    rst = 0; idle();
    check("rst_pend_pcF", pcF, 32'hBFC0_0000);
    step();
    check("rst_pend_next", pcF, 32'hBFC0_0004);

    // Counter saturation and flushE suppression.
    doReset();
    for (int i = 0; i < 21; i++) begin
      branchD = 1; pcD = 32'h3000; branch_targetD = 32'h5000; preErrorE = 1;
      step();
    end
    check("sat4_mcnt", {28'd0, mispred_cnt4}, 32'hF);
    check("sat4_bcnt", {28'd0, branch_cnt4}, 32'hF);
    check("cnt16_mcnt", {16'd0, mispred_cnt}, 32'd20);
    idle();
    flushE = 1; stallE = 1;
    step();
    idle();
    preErrorE = 1;
    #1 check("flushE_noflush", {31'd0, flush_D}, 32'd0);
    step();
    check("flushE_mcnt", {16'd0, mispred_cnt}, 32'd20);
    check("flushE_bcnt", {16'd0, branch_cnt}, 32'd20);

    // Randomized run against the reference model.
    doReset();
    modelReset();
    for (int c = 0; c < 1500; c++) begin
      stallF         = ($urandom_range(0, 9) < 3);
      stallD         = stallF | ($urandom_range(0, 9) == 0);
      stallE         = ($urandom_range(0, 9) < 2);
      flushE         = ($urandom_range(0, 9) == 0);
      branchD        = ($urandom_range(0, 1) == 1);
      pred_takeD     = ($urandom_range(0, 1) == 1);
      pcD            = $urandom & 32'hFFFF_FFFC;
      branch_targetD = $urandom & 32'hFFFF_FFFC;
      actual_takeE   = ($urandom_range(0, 1) == 1);
      preErrorE      = ($urandom_range(0, 9) < 4);
      if (c == 700) rst = 1;
      #1;
      if (!rst) begin
        check("rnd_flush", {31'd0, flush_D}, {31'd0, mPend || (mBr && preErrorE)});
        check("rnd_busy", {31'd0, redirect_busy}, {31'd0, mPend});
      end
      if (rst) modelReset(); else modelEdge();
      step();
      rst = 0;
      check("rnd_pcF", pcF, mPc);
      check("rnd_bcnt", {16'd0, branch_cnt}, mBc);
      check("rnd_mcnt", {16'd0, mispred_cnt}, mMc);
      check("rnd_mcnt4", {28'd0, mispred_cnt4}, mMc4);
    end
    check("rnd_bcnt4", {28'd0, branch_cnt4}, mBc4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
